uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte-request arbiter.
package uart_pkg;

  localparam int NUM_REQ   = 4;
  localparam int REQ_IDX_W = 2;
  localparam int TIMER_W   = 14;

  localparam int ACK_TIMEOUT_DEFAULT  = 4;
  // Covers a full 11-bit frame at the nominal clock and baud with margin.
  localparam int DONE_TIMEOUT_DEFAULT = 12000;

  localparam int ClkFrequency = 100_000_000;
  localparam int Baud         = 115_200;
  localparam int BitCycles    = ClkFrequency / Baud;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE
  } state_e;

  function automatic logic [REQ_IDX_W-1:0] next_idx(input logic [REQ_IDX_W-1:0] idx);
    return (idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k >= N) ? IDX_W'(int'(ptr) + k - N) : IDX_W'(int'(ptr) + k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding single bytes from several requesters to one UART
// transmitter, with handshake timeouts on the transmitter's done level.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = uart_pkg::NUM_REQ,
  parameter int ACK_TIMEOUT  = uart_pkg::ACK_TIMEOUT_DEFAULT,
  parameter int DONE_TIMEOUT = uart_pkg::DONE_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [1:0]             grant_id,
  output logic                   err_timeout,
  output logic [7:0]             err_count
);

  import uart_pkg::*;

  localparam logic [TIMER_W-1:0] ACK_LAST  = TIMER_W'(ACK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DONE_LAST = TIMER_W'(DONE_TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [REQ_IDX_W-1:0] ptr_q, ptr_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [1:0]           grant_id_q, grant_id_d;
  logic                 err_timeout_q, err_timeout_d;
  logic [7:0]           err_count_q, err_count_d;
  logic                 abort;

  logic                 arb_any;
  logic [REQ_IDX_W-1:0] arb_winner;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (REQ_IDX_W)
  ) u_rr_arbiter (
    .req    (req_valid),
    .ptr    (ptr_q),
    .any    (arb_any),
    .winner (arb_winner)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      timer_q       <= '0;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      err_timeout_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      timer_q       <= timer_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    timer_d    = timer_q;
    tx_data_d  = tx_data_q;
    grant_id_d = grant_id_q;
    abort      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          tx_data_d  = req_data[8*arb_winner +: 8];
          grant_id_d = arb_winner;
          state_d    = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!tx_done) begin
          timer_d = '0;
          state_d = WAIT_DONE;
        end else if (timer_q == ACK_LAST) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          ptr_d   = next_idx(grant_id_q);
          state_d = IDLE;
        end else if (timer_q == DONE_LAST) begin
          abort = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A timed-out byte is dropped; the next search starts past its owner.
    if (abort) begin
      ptr_d   = next_idx(grant_id_q);
      state_d = IDLE;
    end
    err_timeout_d = abort;
    err_count_d   = (abort && err_count_q != 8'hFF) ? err_count_q + 1'b1 : err_count_q;
  end

  always_comb begin
    req_ready = '0;
    tx_start  = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE:    if (arb_any) req_ready[arb_winner] = 1'b1;
      START:   tx_start = 1'b1;
      default: ;
    endcase
  end

  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign err_timeout = err_timeout_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed phases with random data and
// masks, a transaction-level round-robin model, and a behavioural UART with TxD decoder.
module tb_uart_tx_arbiter;

  localparam int ACK_T  = 4;
  localparam int DONE_T = 12000;
  localparam int BIT    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        err_timeout;
  logic [7:0]  err_count;

  logic        man_done;
  logic        uart_done = 1'b1;
  logic        uart_en;
  logic        txd = 1'b1;
  logic [9:0]  uart_frame;
  logic [7:0]  mon_byte;
  int          frame_err = 0;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int err_m  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] src_q[4][$];

  always #5 clk = ~clk;

  assign tx_done = uart_en ? uart_done : man_done;

  uart_tx_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout),
    .err_count   (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first pending requester at or after the pointer.
  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    step();
    rst   = 1'b0;
    ptr_m = 0;
    err_m = 0;
    check("rst_busy", busy, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_count", err_count, 0);
  endtask

  // Called in an IDLE cycle; leaves the bench in the START cycle.
  task automatic grant_cycle(input logic [3:0] v, input logic [31:0] d, output int w);
    req_valid = v;
    req_data  = d;
    #1;
    w = rr_pick(v, ptr_m);
    check("idle_busy", busy, 0);
    check("idle_tx_start", tx_start, 0);
    check("idle_req_ready", req_ready, 32'(1) << w);
    step();
    check("start_tx_start", tx_start, 1);
    check("start_tx_data", tx_data, d[8*w +: 8]);
    check("start_grant_id", grant_id, w);
    check("start_req_ready", req_ready, 0);
    check("start_busy", busy, 1);
    check("start_err_timeout", err_timeout, 0);
    ptr_m = (w + 1) % 4;
  endtask

  // From START: acknowledge after a random delay, finish after a random delay.
  task automatic complete_ok(input logic [7:0] b);
    int ack_dly  = $urandom_range(0, ACK_T - 1);
    int done_dly = $urandom_range(0, 20);
    step();
    man_done = 1'b1;
    for (int i = 0; i < ack_dly; i++) begin
      check("ack_busy", busy, 1);
      check("ack_err_timeout", err_timeout, 0);
      step();
    end
    man_done = 1'b0;
    step();
    for (int i = 0; i < done_dly; i++) begin
      check("done_busy", busy, 1);
      check("done_tx_data_stable", tx_data, b);
      check("done_tx_start", tx_start, 0);
      step();
    end
    man_done = 1'b1;
    step();
    check("ok_busy", busy, 0);
    check("ok_err_timeout", err_timeout, 0);
  endtask

  // From START with tx_done stuck high: pulse expected ACK_T cycles after WAIT_ACK entry.
  task automatic abort_ack();
    step();
    man_done = 1'b1;
    for (int i = 0; i < ACK_T; i++) begin
      check("ack_to_no_pulse", err_timeout, 0);
      check("ack_to_busy", busy, 1);
      step();
    end
    err_m = (err_m == 255) ? 255 : err_m + 1;
    check("ack_to_pulse", err_timeout, 1);
    check("ack_to_idle", busy, 0);
    check("ack_to_err_count", err_count, err_m);
  endtask

  // From START: acknowledge at once, then never finish.
  task automatic abort_done();
    int n = 0;
    step();
    man_done = 1'b0;
    step();
    while (err_timeout !== 1'b1 && n < DONE_T + 100) begin
      step();
      n++;
    end
    err_m = (err_m == 255) ? 255 : err_m + 1;
    check("done_to_cycles", n, DONE_T);
    check("done_to_idle", busy, 0);
    check("done_to_err_count", err_count, err_m);
    man_done = 1'b1;
  endtask

  function automatic bit all_src_empty();
    for (int r = 0; r < 4; r++) if (src_q[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Behavioural transmitter: drops done after start, 8N1 frame, raises done after stop.
  initial begin
    forever begin
      @(negedge clk);
      if (uart_en && tx_start) begin
        uart_frame = {1'b1, tx_data, 1'b0};
        @(posedge clk);
        #1;
        uart_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
          txd = uart_frame[i];
          repeat (BIT) @(posedge clk);
          #1;
        end
        txd       = 1'b1;
        uart_done = 1'b1;
      end
    end
  end

  // TxD decoder sampling mid-bit.
  initial begin
    forever begin
      @(negedge txd);
      repeat (BIT / 2) @(negedge clk);
      if (txd !== 1'b0) frame_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        mon_byte[i] = txd;
      end
      repeat (BIT) @(negedge clk);
      if (txd !== 1'b1) frame_err++;
      rx_q.push_back(mon_byte);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int cyc;
    int k;
    logic [31:0] d;
    logic [3:0]  v;
    logic [7:0]  last_b;
    logic [1:0]  last_w;
    logic [7:0]  order_exp [5];
    order_exp = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    man_done  = 1'b1;
    uart_en   = 1'b0;
    repeat (2) step();
    do_reset();

    // Reset while waiting for done, owner 2: silent abandon, pointer back to 0.
    grant_cycle(4'b0100, $urandom, w);
    req_valid = '0;
    step();
    man_done = 1'b0;
    repeat (3) step();
    check("mid_grant_id", grant_id, 2);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    rst   = 1'b0;
    ptr_m = 0;
    man_done = 1'b1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err_timeout", err_timeout, 0);
    check("mid_rst_err_count", err_count, 0);
    check("mid_rst_grant_id", grant_id, 0);
    check("mid_rst_tx_data", tx_data, 0);
    step();
    check("mid_rst_no_late_pulse", err_timeout, 0);
    check("mid_rst_idle", busy, 0);

    // Single requester 0 with 0x55; tx_done undefined while IDLE/START.
    man_done = 1'bx;
    grant_cycle(4'b0001, 32'h0000_0055, w);
    req_valid = '0;
    complete_ok(8'h55);
    d = $urandom;
    grant_cycle(4'b0011, d, w);
    check("ptr_after_first", grant_id, 1);
    req_valid = '0;
    complete_ok(d[15:8]);

    // All four pending: strict rotation with wrap.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      grant_cycle(4'hF, 32'h4030_2010, w);
      check("rr_order", tx_data, order_exp[i]);
      complete_ok(order_exp[i]);
    end

    // Ack timeout, then done timeout.
    grant_cycle(4'hF, $urandom, w);
    abort_ack();
    grant_cycle(4'hF, $urandom, w);
    abort_done();

    // Many ack timeouts with random masks: counter saturates.
    for (int i = 0; i < 256; i++) begin
      v = 4'($urandom_range(1, 15));
      d = $urandom;
      grant_cycle(v, d, w);
      last_b = d[8*w +: 8];
      last_w = 2'(w);
      abort_ack();
    end
    check("err_count_saturated", err_count, 255);

    // Nothing pending: everything holds.
    req_valid = '0;
    #1;
    check("hold_req_ready", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_busy", busy, 0);
      check("hold_tx_data", tx_data, last_b);
      check("hold_grant_id", grant_id, last_w);
      check("hold_err_timeout", err_timeout, 0);
      check("hold_err_count", err_count, 255);
    end

    // Real serial frame of 0xA5.
    uart_en = 1'b1;
    rx_q.delete();
    k = $urandom_range(0, 3);
    d = $urandom;
    d[8*k +: 8] = 8'hA5;
    grant_cycle(4'(1 << k), d, w);
    req_valid = '0;
    cyc = 0;
    while ((busy || rx_q.size() == 0) && cyc < 2000) begin
      step();
      cyc++;
    end
    check("a5_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("a5_rx_byte", rx_q[0], 8'hA5);
    rx_q.delete();

    // Four-way load with requesters randomly withdrawing.
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 5; j++) src_q[r].push_back(8'($urandom));
    cyc = 0;
    while (cyc < 20000 && !(all_src_empty() && !busy && rx_q.size() == exp_q.size())) begin
      v = '0;
      d = '0;
      for (int r = 0; r < 4; r++) begin
        if (src_q[r].size() > 0 && $urandom_range(0, 3) != 0) begin
          v[r] = 1'b1;
          d[8*r +: 8] = src_q[r][0];
        end
      end
      req_valid = v;
      req_data  = d;
      #1;
      if (!busy && v != 0) begin
        w = rr_pick(v, ptr_m);
        check("load_req_ready", req_ready, 32'(1) << w);
        exp_q.push_back(src_q[w].pop_front());
        ptr_m = (w + 1) % 4;
      end else begin
        check("load_req_ready_zero", req_ready, 0);
      end
      step();
      cyc++;
    end
    req_valid = '0;
    check("load_finished", cyc < 20000, 1);
    check("load_rx_count", rx_q.size(), exp_q.size());
    check("load_all_sent", exp_q.size(), 20);
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check("load_rx_byte", rx_q[i], exp_q[i]);
    check("frame_errors", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
